nrzi_eop_encode: RTL and testbench

NRZI_EOP_ENCODE -- requirements
Module: nrzi_eop_encode

---
 rtl/nrzi_eop_encode_if.sv | 23 ++
 rtl/nrzi_eop_encode.sv | 123 ++++++++++++
 tb/tb_nrzi_eop_encode.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nrzi_eop_encode_if.sv
// Serial input and USB line-side signals of the NRZI / EOP encoder.
// The encoder side uses the slave modport; the bit source and bus observer use master.
`timescale 1ns/1ps
interface nrzi_eop_encode_if;
   logic        in_bit;
   logic        in_valid;
   logic        dp;
   logic        dm;
   logic        wires_en;
   logic        eop_done;
   logic        overrun;
   logic [15:0] bits_sent;

   modport master (
      output in_bit, in_valid,
      input  dp, dm, wires_en, eop_done, overrun, bits_sent
   );

   modport slave (
      input  in_bit, in_valid,
      output dp, dm, wires_en, eop_done, overrun, bits_sent
   );
endinterface

// File: rtl/nrzi_eop_encode.sv
// NRZI line encoder with SE0,SE0,J end-of-packet generation for a USB transmitter.
// Line outputs are decoded from state and the line-level register only.
`timescale 1ns/1ps
module nrzi_eop_encode (
   input  logic             clock,
   input  logic             reset_n,
   nrzi_eop_encode_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      EOP_SE0_1,
      EOP_SE0_2,
      EOP_J
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        lvl;
   logic        lvl_nxt;
   logic        overrun_q;
   logic        overrun_nxt;
   logic [15:0] count;
   logic [15:0] count_nxt;

   logic        dp_c;
   logic        dm_c;
   logic        wires_en_c;
   logic        eop_done_c;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         lvl       <= 1'b1;
         overrun_q <= 1'b0;
         count     <= '0;
      end else begin
         state     <= state_nxt;
         lvl       <= lvl_nxt;
         overrun_q <= overrun_nxt;
         count     <= count_nxt;
      end
   end

   // Starting from J, the first bit's NRZI level is simply the bit itself.
   always_comb begin
      state_nxt   = state;
      lvl_nxt     = lvl;
      count_nxt   = count;
      overrun_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               state_nxt = SEND;
               lvl_nxt   = bus.in_bit;
               count_nxt = 16'd1;
            end
         end
         SEND: begin
            if (bus.in_valid) begin
               lvl_nxt = bus.in_bit ? lvl : ~lvl;
               if (count != '1) begin
                  count_nxt = count + 16'd1;
               end
            end else begin
               state_nxt = EOP_SE0_1;
            end
         end
         EOP_SE0_1: begin
            overrun_nxt = bus.in_valid;
            state_nxt   = EOP_SE0_2;
         end
         EOP_SE0_2: begin
            overrun_nxt = bus.in_valid;
            state_nxt   = EOP_J;
         end
         EOP_J: begin
            overrun_nxt = bus.in_valid;
            lvl_nxt     = 1'b1;
            state_nxt   = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            lvl_nxt   = 1'b1;
         end
      endcase
   end

   always_comb begin
      dp_c       = 1'b1;
      dm_c       = 1'b0;
      wires_en_c = 1'b1;
      eop_done_c = 1'b0;
      unique case (state)
         IDLE: begin
            wires_en_c = 1'b0;
         end
         SEND: begin
            dp_c = lvl;
            dm_c = ~lvl;
         end
         EOP_SE0_1, EOP_SE0_2: begin
            dp_c = 1'b0;
            dm_c = 1'b0;
         end
         EOP_J: begin
            eop_done_c = 1'b1;
         end
         default: begin
            wires_en_c = 1'b0;
         end
      endcase
   end

   assign bus.dp        = dp_c;
   assign bus.dm        = dm_c;
   assign bus.wires_en  = wires_en_c;
   assign bus.eop_done  = eop_done_c;
   assign bus.overrun   = overrun_q;
   assign bus.bits_sent = count;

endmodule

// File: tb/tb_nrzi_eop_encode.sv
// Scoreboard bench for nrzi_eop_encode: the driver queues expected line cycles,
// a monitor pops one entry for every cycle the encoder drives the bus.
`timescale 1ns/1ps
module tb_nrzi_eop_encode;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [3:0]  exp_q[$];       // {dp, dm, eop_done, overrun}
   logic [3:0]  mon_exp;

   nrzi_eop_encode_if bus ();

   nrzi_eop_encode dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic b);
      @(negedge clock);
      bus.in_valid = v;
      bus.in_bit   = b;
   endtask

   // Bits beyond index 15 are zeros, whose NRZI level alternates 0,1,0,1...
   task automatic send_packet(input int n, input logic [15:0] bits, input logic [15:0] exp_dp,
                              input int slot, input string name);
      logic        b;
      logic        e;
      logic [15:0] exp_cnt;
      for (int i = 0; i < n; i++) begin
         b = (i < 16) ? bits[i] : 1'b0;
         e = (i < 16) ? exp_dp[i] : i[0];
         exp_q.push_back({e, ~e, 1'b0, 1'b0});
         drive(1'b1, b);
      end
      exp_q.push_back(4'b0000);
      exp_q.push_back({3'b000, slot == 1});
      exp_q.push_back({3'b101, slot == 2});
      drive(1'b0, 1'b0);
      drive(slot == 1, 1'b0);
      drive(slot == 2, 1'b0);
      drive(1'b0, 1'b0);
      @(posedge clock);
      #1;
      exp_cnt = (n > 65535) ? 16'hFFFF : n[15:0];
      check({name, "_idle_wires_en"}, bus.wires_en, 1'b0);
      check({name, "_idle_line"}, {bus.dp, bus.dm, bus.eop_done}, 3'b100);
      check({name, "_idle_overrun"}, bus.overrun, 1'b0);
      check({name, "_bits_sent"}, bus.bits_sent, exp_cnt);
   endtask

   // Monitor: every cycle the bus is driven must match the next queued entry.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (bus.wires_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL line_unexpected: got dp=%b dm=%b eop=%b ovr=%b expected no bus drive (t=%0t)",
                        bus.dp, bus.dm, bus.eop_done, bus.overrun, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               check("line_dp_dm_eop_ovr", {bus.dp, bus.dm, bus.eop_done, bus.overrun}, mon_exp);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_line", {bus.dp, bus.dm, bus.wires_en, bus.eop_done}, 4'b1000);
      check("reset_overrun", bus.overrun, 1'b0);
      check("reset_bits_sent", bus.bits_sent, 16'h0000);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // 0000_0001: alternating levels then a held bit
      send_packet(8, 16'h0080, 16'h002A, 0, "p_zeros");
      // eight 1s: line stays at J
      send_packet(8, 16'h00FF, 16'h00FF, 0, "p_ones");
      // single 0
      send_packet(1, 16'h0000, 16'h0000, 0, "p_single0");
      // 1,0,1,1,0,0,1,0 with in_valid during SE0_1
      send_packet(8, 16'h004D, 16'h0091, 1, "p_mixed_ovr1");
      // 1,1,0 with in_valid during SE0_2, then a fresh packet from J
      send_packet(3, 16'h0003, 16'h0003, 2, "p_ovr2");
      send_packet(1, 16'h0000, 16'h0000, 0, "p_after_ovr");

      // Reset during the fourth bit of 0,0,1,0
      exp_q.push_back(4'b0100);
      drive(1'b1, 1'b0);
      exp_q.push_back(4'b1000);
      drive(1'b1, 1'b0);
      exp_q.push_back(4'b1000);
      drive(1'b1, 1'b1);
      exp_q.push_back(4'b0100);
      drive(1'b1, 1'b0);
      @(posedge clock);
      #2;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("midreset_line", {bus.dp, bus.dm, bus.wires_en, bus.eop_done}, 4'b1000);
      check("midreset_bits_sent", bus.bits_sent, 16'h0000);
      check("midreset_queue", exp_q.size(), 0);
      @(negedge clock);
      reset_n = 1'b1;
      // 0,1 after reset: levels 0,0
      send_packet(2, 16'h0002, 16'h0000, 0, "p_after_reset");

      // Long zero-bit packet: counter saturates, encoding keeps alternating
      send_packet(70000, 16'h0000, 16'hAAAA, 0, "p_long");

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
